fetch_redirect_ctrl: RTL and testbench

FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

---
 rtl/fetch_redirect_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect and debug-halt controller: picks the next-PC redirect and sequences halt via a drain window.
// Optional redirect statistics counter is built only when RCTRL_STATS_EN is defined.
module fetch_redirect_ctrl #(
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int unsigned DRAIN_CYC = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall,
    input  logic             ex_redirect_taken,
    input  logic [31:0]      ex_branch_target,
    input  logic             trap_req,
    input  logic             mret_req,
    input  logic [31:0]      mepc,
    input  logic             halt_req,
    input  logic             resume_req,
    input  logic [31:0]      resume_pc,
    output logic             pc_stall,
    output logic             pc_redirect_valid,
    output logic [31:0]      pc_redirect_target,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_RESUME = 2'd3;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [3:0]  drain_cnt_r;
    logic [3:0]  drain_cnt_nxt_s;

    logic        ex_sel_s;
    logic [31:0] ex_target_s;

    logic        pc_stall_s;
    logic        redirect_valid_s;
    logic [31:0] redirect_target_s;
    logic        flush_s;
    logic        halted_s;

    // Fixed-priority pick among the EX-stage redirect sources
    always_comb begin
        ex_sel_s    = 1'b0;
        ex_target_s = 32'h0000_0000;
        if (trap_req) begin
            ex_sel_s    = 1'b1;
            ex_target_s = TRAP_VEC;
        end else if (mret_req) begin
            ex_sel_s    = 1'b1;
            ex_target_s = mepc;
        end else if (ex_redirect_taken) begin
            ex_sel_s    = 1'b1;
            ex_target_s = ex_branch_target;
        end else begin
            ex_sel_s    = 1'b0;
            ex_target_s = 32'h0000_0000;
        end
    end

    // Output decode; a redirect always wins over stall, and reset forces everything quiet
    always_comb begin
        pc_stall_s        = 1'b0;
        redirect_valid_s  = 1'b0;
        redirect_target_s = 32'h0000_0000;
        flush_s           = 1'b0;
        halted_s          = 1'b0;
        case (state_r)
            ST_RUN, ST_DRAIN: begin
                if (ex_sel_s) begin
                    redirect_valid_s  = 1'b1;
                    redirect_target_s = ex_target_s;
                    flush_s           = 1'b1;
                end else if (state_r == ST_DRAIN) begin
                    pc_stall_s = 1'b1;
                end else begin
                    pc_stall_s = hazard_stall;
                end
            end
            ST_HALTED: begin
                pc_stall_s = 1'b1;
                halted_s   = 1'b1;
            end
            ST_RESUME: begin
                redirect_valid_s  = 1'b1;
                redirect_target_s = resume_pc;
                flush_s           = 1'b1;
            end
            default: begin
                pc_stall_s = 1'b0;
            end
        endcase
        if (!rst_n) begin
            pc_stall_s        = 1'b0;
            redirect_valid_s  = 1'b0;
            redirect_target_s = 32'h0000_0000;
            flush_s           = 1'b0;
            halted_s          = 1'b0;
        end else begin
            halted_s = halted_s;
        end
    end

    // Next-state and drain counter; a redirect during drain restarts the window
    always_comb begin
        state_nxt_s     = state_r;
        drain_cnt_nxt_s = 4'd0;
        case (state_r)
            ST_RUN: begin
                if (halt_req && !ex_sel_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!halt_req) begin
                    state_nxt_s = ST_RUN;
                end else if (ex_sel_s) begin
                    state_nxt_s = ST_DRAIN;
                end else if (drain_cnt_r >= DRAIN_LAST) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s     = ST_DRAIN;
                    drain_cnt_nxt_s = drain_cnt_r + 4'd1;
                end
            end
            ST_HALTED: begin
                if (resume_req) begin
                    state_nxt_s = ST_RESUME;
                end else begin
                    state_nxt_s = ST_HALTED;
                end
            end
            ST_RESUME: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State and drain counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
        end
    end

    assign pc_stall           = pc_stall_s;
    assign pc_redirect_valid  = redirect_valid_s;
    assign pc_redirect_target = redirect_target_s;
    assign flush_if_id        = flush_s;
    assign flush_id_ex        = flush_s;
    assign halted             = halted_s;

`ifdef RCTRL_STATS_EN
    logic [CNT_W-1:0] redirect_cnt_r;

    // Count every cycle that loads a redirect into the PC; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_cnt_r <= '0;
        end else if (redirect_valid_s) begin
            redirect_cnt_r <= redirect_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            redirect_cnt_r <= redirect_cnt_r;
        end
    end

    assign redirect_cnt = redirect_cnt_r;
`else
    assign redirect_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: directed scenarios plus random traffic vs a drain-countdown model.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
    localparam int          DRAIN_CYC = 3;
    localparam int          CNT_W     = 4;

`ifdef RCTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hazard_stall = 1'b0;
    logic             ex_redirect_taken = 1'b0;
    logic [31:0]      ex_branch_target = 32'h0;
    logic             trap_req = 1'b0;
    logic             mret_req = 1'b0;
    logic [31:0]      mepc = 32'h0;
    logic             halt_req = 1'b0;
    logic             resume_req = 1'b0;
    logic [31:0]      resume_pc = 32'h0;
    logic             pc_stall;
    logic             pc_redirect_valid;
    logic [31:0]      pc_redirect_target;
    logic             flush_if_id;
    logic             flush_id_ex;
    logic             halted;
    logic [CNT_W-1:0] redirect_cnt;

    fetch_redirect_ctrl #(
        .TRAP_VEC (TRAP_VEC),
        .DRAIN_CYC(DRAIN_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hazard_stall      (hazard_stall),
        .ex_redirect_taken (ex_redirect_taken),
        .ex_branch_target  (ex_branch_target),
        .trap_req          (trap_req),
        .mret_req          (mret_req),
        .mepc              (mepc),
        .halt_req          (halt_req),
        .resume_req        (resume_req),
        .resume_pc         (resume_pc),
        .pc_stall          (pc_stall),
        .pc_redirect_valid (pc_redirect_valid),
        .pc_redirect_target(pc_redirect_target),
        .flush_if_id       (flush_if_id),
        .flush_id_ex       (flush_id_ex),
        .halted            (halted),
        .redirect_cnt      (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             stall;
        logic             valid;
        logic [31:0]      target;
        logic             fif;
        logic             fid;
        logic             hlt;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: halted / resuming flags and a countdown of drain cycles left
    bit          m_halted = 1'b0;
    bit          m_resuming = 1'b0;
    int          m_drain_left = 0;
    int unsigned m_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_halted     = 1'b0;
        m_resuming   = 1'b0;
        m_drain_left = 0;
        m_cnt        = 0;
    endtask

    task automatic model_step();
        exp_t        e;
        logic        cand_v;
        logic [31:0] cand_t;
        cand_v = 1'b0;
        cand_t = 32'h0;
        if (trap_req) begin
            cand_v = 1'b1; cand_t = TRAP_VEC;
        end else if (mret_req) begin
            cand_v = 1'b1; cand_t = mepc;
        end else if (ex_redirect_taken) begin
            cand_v = 1'b1; cand_t = ex_branch_target;
        end
        e = '0;
        e.cnt = STATS ? CNT_W'(m_cnt % (1 << CNT_W)) : '0;
        if (m_resuming) begin
            e.valid = 1'b1; e.target = resume_pc; e.fif = 1'b1; e.fid = 1'b1;
        end else if (m_halted) begin
            e.stall = 1'b1; e.hlt = 1'b1;
        end else if (cand_v) begin
            e.valid = 1'b1; e.target = cand_t; e.fif = 1'b1; e.fid = 1'b1;
        end else begin
            e.stall = (m_drain_left > 0) ? 1'b1 : hazard_stall;
        end
        exp_q.push_back(e);
        if (e.valid) m_cnt++;
        if (m_resuming) begin
            m_resuming = 1'b0;
        end else if (m_halted) begin
            if (resume_req) begin
                m_halted = 1'b0; m_resuming = 1'b1;
            end
        end else if (m_drain_left > 0) begin
            if (!halt_req) m_drain_left = 0;
            else if (cand_v) m_drain_left = DRAIN_CYC;
            else if (m_drain_left == 1) begin
                m_drain_left = 0; m_halted = 1'b1;
            end else m_drain_left--;
        end else if (halt_req && !cand_v) begin
            m_drain_left = DRAIN_CYC;
        end
    endtask

    task automatic drive(input logic hz, input logic ex, input logic [31:0] bt,
                         input logic tr, input logic mr, input logic [31:0] mp,
                         input logic hr, input logic rs, input logic [31:0] rp);
        hazard_stall      = hz;
        ex_redirect_taken = ex;
        ex_branch_target  = bt;
        trap_req          = tr;
        mret_req          = mr;
        mepc              = mp;
        halt_req          = hr;
        resume_req        = rs;
        resume_pc         = rp;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_stall"}, {31'd0, pc_stall}, 32'd0);
        check({nm, "_valid"}, {31'd0, pc_redirect_valid}, 32'd0);
        check({nm, "_target"}, pc_redirect_target, 32'd0);
        check({nm, "_flush"}, {30'd0, flush_if_id, flush_id_ex}, 32'd0);
        check({nm, "_halted"}, {31'd0, halted}, 32'd0);
        check({nm, "_cnt"}, {{(32-CNT_W){1'b0}}, redirect_cnt}, 32'd0);
    endtask

    // Monitor: every active cycle presents a full output set; compare it with the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc_stall", {31'd0, pc_stall}, {31'd0, e.stall});
            check("pc_redirect_valid", {31'd0, pc_redirect_valid}, {31'd0, e.valid});
            check("pc_redirect_target", pc_redirect_target, e.target);
            check("flush_if_id", {31'd0, flush_if_id}, {31'd0, e.fif});
            check("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, e.fid});
            check("halted", {31'd0, halted}, {31'd0, e.hlt});
            check("redirect_cnt", {{(32-CNT_W){1'b0}}, redirect_cnt}, {{(32-CNT_W){1'b0}}, e.cnt});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic hr_lvl;
        // Reset with active requests: outputs must stay quiet
        trap_req = 1'b1; hazard_stall = 1'b1; halt_req = 1'b1;
        #2;
        check_quiet("reset");
        trap_req = 1'b0; hazard_stall = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Hazard pulse of two cycles
        idle(1);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        idle(2);

        // All three redirect sources at once, then mret vs branch, branch vs hazard
        drive(1, 1, 32'h40, 1, 1, 32'h3000, 0, 0, 32'h0);
        idle(1);
        drive(0, 1, 32'h44, 0, 1, 32'h1234, 0, 0, 32'h0);
        drive(1, 1, 32'h48, 0, 0, 32'h0, 0, 0, 32'h0);
        idle(1);

        // Halt with full drain, redirects ignored while halted, resume to 0x200
        repeat (5) drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        drive(1, 1, 32'h60, 1, 0, 32'h0, 1, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h200);
        drive(0, 1, 32'h64, 0, 0, 32'h0, 0, 0, 32'h200);
        idle(2);

        // Branch on the second drain cycle restarts the window; resume with halt still high
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        drive(0, 1, 32'h80, 0, 0, 32'h0, 1, 0, 32'h0);
        repeat (4) drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 32'h300);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h300);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        idle(2);

        // Stray resume in RUN; halt colliding with a redirect
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h500);
        idle(1);
        drive(0, 1, 32'h90, 0, 0, 32'h0, 1, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        drive(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
        idle(1);

        // Random traffic with a slowly toggling halt level
        hr_lvl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) hr_lvl = ~hr_lvl;
            drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 4) == 0), $urandom,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0), $urandom,
                  hr_lvl, ($urandom_range(0, 4) == 0), $urandom);
        end

        // Reach HALTED, then assert reset between clock edges
        repeat (6) drive(0, 0, 32'h0, 0, 0, 32'h0, 1, 0, 32'h0);
        check("pre_reset_halted", {31'd0, halted}, 32'd1);
        halt_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_halted", {31'd0, halted}, 32'd0);
        check("async_reset_stall", {31'd0, pc_stall}, 32'd0);
        trap_req = 1'b1; hazard_stall = 1'b1; halt_req = 1'b1;
        @(negedge clk);
        check_quiet("reset_hold");
        trap_req = 1'b0; hazard_stall = 1'b0; halt_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Seventeen redirects from a cleared counter
        repeat (17) drive(0, 1, 32'hA0, 0, 0, 32'h0, 0, 0, 32'h0);
        check("cnt_after_17", {{(32-CNT_W){1'b0}}, redirect_cnt}, STATS ? 32'd1 : 32'd0);
        idle(2);

        @(negedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
